chien_sched: RTL and testbench

- Sequencer for the BCH Chien search datapath.
- Accepts an error-locator polynomial over a valid/ready handshake, then drives the datapath controls:
  - chpe: one-cycle load of the coefficients.
  - cei: one step per codeword position.
- Streams a per-position error flag with backpressure.
- Reports a decode status at the end: error count, and decode failure when the count disagrees with the locator degree.

---
 rtl/chien_sched.sv | 149 ++++++++++++++
 tb/tb_chien_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chien_sched.sv
// Chien search sequencer: accepts a BCH error-locator polynomial, loads it into
// the datapath (chpe), steps the datapath once per accepted position beat (cei),
// streams per-position error flags and reports error count / decode failure.
// Optional build macro: CHIEN_SCHED_EARLY_EXIT_EN (stop once count reaches deg).
module chien_sched #(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3,
    parameter int unsigned N = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M*(T+1)-1:0]   in_sigma,
    input  logic [7:0]           in_deg,
    output logic                 chpe,
    output logic                 cei,
    output logic [M*(T+1)-1:0]   cNout,
    input  logic                 ch_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_pos,
    output logic                 out_err,
    output logic                 out_last,
    output logic                 st_valid,
    output logic [7:0]           st_count,
    output logic                 st_fail
);

    localparam int unsigned SW = M * (T + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] cnout_q, cnout_d;
    logic [7:0]    deg_q, deg_d;
    logic [7:0]    pos_q, pos_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    st_count_q, st_count_d;
    logic          st_fail_q, st_fail_d;

    logic          run_c;
    logic          deg_ok_c;
    logic [7:0]    count_inc_c;
    logic          last_c;

    // Beat bookkeeping: saturating error count and end-of-search detection
    always_comb begin
        run_c       = (state_q == S_RUN);
        deg_ok_c    = (deg_q <= 8'(T));
        count_inc_c = (ch_err && (count_q != 8'hFF)) ? (count_q + 8'd1) : count_q;
`ifdef CHIEN_SCHED_EARLY_EXIT_EN
        last_c      = (pos_q == 8'(N - 1)) ||
                      (deg_ok_c && (deg_q != 8'd0) && (count_inc_c == deg_q));
`else
        last_c      = (pos_q == 8'(N - 1));
`endif
    end

    // Next-state and register update logic
    always_comb begin
        state_d    = state_q;
        cnout_d    = cnout_q;
        deg_d      = deg_q;
        pos_d      = pos_q;
        count_d    = count_q;
        st_count_d = st_count_q;
        st_fail_d  = st_fail_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cnout_d = in_sigma;
                    deg_d   = in_deg;
                    pos_d   = 8'd0;
                    count_d = 8'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
`ifdef CHIEN_SCHED_EARLY_EXIT_EN
                // A degree-0 locator has no roots: nothing to search
                if (deg_q == 8'd0) begin
                    state_d    = S_DONE;
                    st_count_d = 8'd0;
                    st_fail_d  = 1'b0;
                end
`endif
            end
            S_RUN: begin
                if (out_ready) begin
                    pos_d   = pos_q + 8'd1;
                    count_d = count_inc_c;
                    if (last_c) begin
                        state_d    = S_DONE;
                        st_count_d = count_inc_c;
                        st_fail_d  = (count_inc_c != deg_q) || !deg_ok_c;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath-facing registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnout_q    <= '0;
            deg_q      <= 8'd0;
            pos_q      <= 8'd0;
            count_q    <= 8'd0;
            st_count_q <= 8'd0;
            st_fail_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnout_q    <= cnout_d;
            deg_q      <= deg_d;
            pos_q      <= pos_d;
            count_q    <= count_d;
            st_count_q <= st_count_d;
            st_fail_q  <= st_fail_d;
        end
    end

    // Output decode; out_err/out_last/cei follow the live datapath and consumer
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        chpe      = (state_q == S_LOAD);
        out_valid = run_c;
        cei       = run_c && out_ready;
        out_pos   = run_c ? pos_q : 8'd0;
        out_err   = run_c && ch_err;
        out_last  = run_c && last_c;
        st_valid  = (state_q == S_DONE);
        st_count  = st_count_q;
        st_fail   = st_fail_q;
        cNout     = cnout_q;
    end

endmodule

// File: tb/tb_chien_sched.sv
// Bench for chien_sched: a GF(16) Chien datapath model feeds ch_err; expected
// beats come from direct polynomial evaluation and are checked via scoreboard.
module tb_chien_sched;

    localparam int unsigned M  = 4;
    localparam int unsigned T  = 3;
    localparam int unsigned N  = 15;
    localparam int unsigned SW = M * (T + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sigma;
    logic [7:0]    in_deg;
    logic          chpe;
    logic          cei;
    logic [SW-1:0] cNout;
    logic          ch_err;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_pos;
    logic          out_err;
    logic          out_last;
    logic          st_valid;
    logic [7:0]    st_count;
    logic          st_fail;

    chien_sched #(.M(M), .T(T), .N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sigma(in_sigma), .in_deg(in_deg),
        .chpe(chpe), .cei(cei), .cNout(cNout), .ch_err(ch_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .out_err(out_err), .out_last(out_last),
        .st_valid(st_valid), .st_count(st_count), .st_fail(st_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(2^4) arithmetic, primitive polynomial x^4+x+1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ x;
            x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_apow(input int e);
        logic [3:0] r;
        r = 4'h1;
        for (int k = 0; k < (e % 15); k++) r = gf_mul(r, 4'h2);
        return r;
    endfunction

    function automatic logic poly_root(input logic [SW-1:0] s, input int j);
        logic [3:0] acc_v;
        acc_v = 4'h0;
        for (int i = 0; i <= int'(T); i++) acc_v = acc_v ^ gf_mul(s[i*M +: M], gf_apow(i * j));
        return (acc_v == 4'h0);
    endfunction

    // Chien datapath model: load on chpe, multiply term i by alpha^i on cei
    logic [3:0] r [T+1];
    logic [3:0] acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= int'(T); i++) r[i] <= 4'h0;
        end else if (chpe) begin
            for (int i = 0; i <= int'(T); i++) r[i] <= cNout[i*M +: M];
        end else if (cei) begin
            for (int i = 0; i <= int'(T); i++) r[i] <= gf_mul(r[i], gf_apow(i));
        end
    end
    always_comb begin
        acc = 4'h0;
        for (int i = 0; i <= int'(T); i++) acc = acc ^ r[i];
        ch_err = (acc == 4'h0);
    end

    typedef struct packed {
        logic [7:0] pos;
        logic       err;
        logic       last;
    } beat_t;
    typedef struct packed {
        logic [7:0] cnt;
        logic       fail;
    } stat_t;
    typedef struct {
        logic [SW-1:0] sigma;
        logic [7:0]    deg;
        logic          bp;
        logic [7:0]    exp_cnt;
        logic          exp_fail;
    } vec_t;

    beat_t beat_q[$];
    stat_t stat_q[$];
    logic  bp_mode;

    // Consumer backpressure, changed just after each rising edge
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Output monitor, sampled on the falling edge
    initial begin
        logic       prev_stall;
        logic [7:0] prev_pos;
        logic       prev_err;
        beat_t      b;
        stat_t      s;
        prev_stall = 1'b0;
        prev_pos   = 8'd0;
        prev_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (chpe) chk("chpe_cei_excl", 32'(cei), 32'd0);
                if (out_valid || cei) chk("cei_eq_accept", 32'(cei), 32'(out_valid & out_ready));
                if (out_valid) chk("in_ready_in_run", 32'(in_ready), 32'd0);
                if (prev_stall) begin
                    chk("stall_pos", 32'(out_pos), 32'(prev_pos));
                    chk("stall_err", 32'(out_err), 32'(prev_err));
                end
                if (out_valid && out_ready) begin
                    if (beat_q.size() == 0) begin
                        chk("beat_expected", 32'(beat_q.size()), 32'd1);
                    end else begin
                        b = beat_q.pop_front();
                        chk("out_pos", 32'(out_pos), 32'(b.pos));
                        chk("out_err", 32'(out_err), 32'(b.err));
                        chk("out_last", 32'(out_last), 32'(b.last));
                    end
                end
                if (st_valid) begin
                    if (stat_q.size() == 0) begin
                        chk("st_unexpected", 32'(st_valid), 32'd0);
                    end else begin
                        s = stat_q.pop_front();
                        chk("st_count", 32'(st_count), 32'(s.cnt));
                        chk("st_fail", 32'(st_fail), 32'(s.fail));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_pos   = out_pos;
                prev_err   = out_err;
            end
        end
    end

    // Push the expected beat stream and status for one locator
    task automatic build_expect(input vec_t v, output int nbeats);
        int    c;
        logic  e;
        logic  stop;
        beat_t b;
        c = 0;
        nbeats = 0;
`ifdef CHIEN_SCHED_EARLY_EXIT_EN
        if (v.deg != 8'd0) begin
`else
        begin
`endif
            for (int j = 0; j < int'(N); j++) begin
                e = poly_root(v.sigma, j);
                if (e) c++;
`ifdef CHIEN_SCHED_EARLY_EXIT_EN
                stop = (v.deg <= 8'(T)) && (c == int'(v.deg));
`else
                stop = 1'b0;
`endif
                b.pos  = 8'(j);
                b.err  = e;
                b.last = (j == int'(N) - 1) || stop;
                beat_q.push_back(b);
                nbeats++;
                if (b.last) break;
            end
        end
        stat_q.push_back('{cnt: v.exp_cnt, fail: v.exp_fail});
    endtask

    task automatic start_job(input vec_t v, output int nbeats);
        int ok;
        build_expect(v, nbeats);
        bp_mode = v.bp;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("in_ready_wait", 32'(ok), 32'd1);
        in_valid = 1'b1;
        in_sigma = v.sigma;
        in_deg   = v.deg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sigma = SW'($urandom);
        in_deg   = 8'($urandom);
        @(negedge clk);
        chk("load_chpe", 32'(chpe), 32'd1);
        chk("load_in_ready", 32'(in_ready), 32'd0);
        chk("load_out_valid", 32'(out_valid), 32'd0);
        chk("load_cnout", 32'(cNout), 32'(v.sigma));
        @(negedge clk);
        chk("first_valid", 32'(out_valid), 32'(nbeats != 0));
    endtask

    task automatic run_job(input vec_t v);
        int nb;
        int got;
        start_job(v, nb);
        got = 0;
        for (int c = 0; c < 400; c++) begin
            if (st_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("st_seen", 32'(got), 32'd1);
        chk("beats_drained", 32'(beat_q.size()), 32'd0);
        @(negedge clk);
        chk("st_one_cycle", 32'(st_valid), 32'd0);
        chk("st_hold_count", 32'(st_count), 32'(v.exp_cnt));
        chk("st_hold_fail", 32'(st_fail), 32'(v.exp_fail));
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    vec_t tbl [8];

    initial begin
        int nb;
        int found;
        int pulses;
        tbl[0] = '{sigma: 16'h0001, deg: 8'd0, bp: 1'b0, exp_cnt: 8'd0, exp_fail: 1'b0};
        tbl[1] = '{sigma: 16'h0011, deg: 8'd1, bp: 1'b0, exp_cnt: 8'd1, exp_fail: 1'b0};
        tbl[2] = '{sigma: 16'h0011, deg: 8'd2, bp: 1'b0, exp_cnt: 8'd1, exp_fail: 1'b1};
        tbl[3] = '{sigma: 16'h0011, deg: 8'd1, bp: 1'b1, exp_cnt: 8'd1, exp_fail: 1'b0};
        tbl[4] = '{sigma: 16'h0011, deg: 8'd5, bp: 1'b0, exp_cnt: 8'd1, exp_fail: 1'b1};
        tbl[5] = '{sigma: 16'h0231, deg: 8'd2, bp: 1'b0, exp_cnt: 8'd2, exp_fail: 1'b0};
        tbl[6] = '{sigma: 16'h0081, deg: 8'd1, bp: 1'b1, exp_cnt: 8'd1, exp_fail: 1'b0};
        tbl[7] = '{sigma: 16'h0231, deg: 8'd2, bp: 1'b1, exp_cnt: 8'd2, exp_fail: 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sigma = '0;
        in_deg   = 8'd0;
        bp_mode  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_chpe", 32'(chpe), 32'd0);
        chk("rst_cei", 32'(cei), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_st_valid", 32'(st_valid), 32'd0);
        chk("rst_st_fail", 32'(st_fail), 32'd0);
        chk("rst_out_pos", 32'(out_pos), 32'd0);
        chk("rst_st_count", 32'(st_count), 32'd0);
        chk("rst_cnout", 32'(cNout), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Reset in the middle of a search at position 7
        start_job(tbl[6], nb);
        found = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid && out_pos == 8'd7) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_pos7", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_pos", 32'(out_pos), 32'd0);
        chk("midrst_cei", 32'(cei), 32'd0);
        chk("midrst_cnout", 32'(cNout), 32'd0);
        chk("midrst_st_count", 32'(st_count), 32'd0);
        beat_q.delete();
        stat_q.delete();
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (st_valid) pulses++;
        end
        chk("no_st_after_reset", 32'(pulses), 32'd0);

        run_job(tbl[5]);
        run_job(tbl[1]);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
